fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the core. It owns the program counter and issues one instruction-memory read at a time over a request/grant/response handshake. It presents each fetched word to decode with a valid/ready handshake. Redirects come from the branch/jump resolution path, whose targets are built from decoded immediates, and the block discards any in-flight fetch that a redirect makes stale.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- i_clk  input  1  core clock; all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- o_imem_req  output  1  read request valid; high only in REQ
- o_imem_addr  output  32  read address; equals PC while o_imem_req=1
- i_imem_gnt  input  1  memory accepts the request this cycle
- i_imem_rvalid  input  1  read data returned this cycle; at most one per accepted request
- i_imem_rdata  input  32  returned instruction word
- o_inst_valid  output  1  o_inst/o_inst_pc hold a live instruction
- o_inst  output  32  fetched instruction word
- o_inst_pc  output  32  address of o_inst
- i_inst_ready  input  1  decode consumes the instruction this cycle
- i_redirect  input  1  control-flow change; single-cycle pulse
- i_redirect_target  input  32  new PC when i_redirect=1
- o_trap  output  1  misaligned redirect detected (only with FETCH_MISALIGN_TRAP_EN)
- o_trap_addr  output  32  offending target

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT (HALT exists only with macro).
- IDLE -> REQ unconditionally. This is the single post-reset cycle.
- REQ: o_imem_req=1 and o_imem_addr=pc. When i_imem_gnt=1, go to WAIT; otherwise stay in REQ.
- WAIT: wait for i_imem_rvalid.
  - If kill=0: latch rdata into o_inst and pc into o_inst_pc, then go to HOLD.
  - If kill=1: drop the word, clear kill, then go to REQ.
- HOLD: o_inst_valid=1. When i_inst_ready=1, set pc to pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC) and go to REQ.
- Redirect, handled in any state except IDLE and HALT; pc is always set to the target:
  - REQ with gnt=0: stay in REQ. o_imem_addr changes to the target next cycle, which is legal because the request was not yet accepted.
  - REQ with gnt=1: go to WAIT with kill=1.
  - WAIT without rvalid: set kill=1.
  - WAIT with rvalid in the same cycle: drop the word and go to REQ.
  - HOLD: drop the instruction and go to REQ. If i_inst_ready is also high, the redirect wins: the instruction counts as consumed and pc becomes the target, not pc+4.
- At most one outstanding memory request at any time.
- i_rst asserted mid-operation: everything returns to reset values immediately. Any response arriving after reset is the memory's responsibility and is not tracked.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_ADDR, kill=0
  - o_imem_req=0, o_imem_addr=RESET_ADDR
  - o_inst_valid=0, o_inst=0, o_inst_pc=0
  - o_trap=0, o_trap_addr=0
- o_imem_req, o_imem_addr and o_inst_valid are decoded from registered state and pc only. There is no combinational path from any input to any output.
- Best case with gnt in the REQ cycle and rvalid the next cycle: REQ(c0), WAIT(c1), HOLD(c2) with valid. With ready in c2, the next REQ is in c3. Throughput is one instruction per 3 cycles.
- First fetch request appears 2 cycles after i_rst deasserts (IDLE, then REQ).
- Redirect effect: the target appears on o_imem_addr at the first REQ cycle after the redirect edge.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with target[1:0]!=0 sets o_trap=1 and o_trap_addr=target, and moves the FSM to HALT.
  - HALT: no requests, o_inst_valid=0, o_trap held high, further redirects ignored; exit only by reset.
  - Any in-flight response arriving in HALT is ignored.
- Undefined: target[1:0] is forced to 2'b00. o_trap and o_trap_addr are tied to 0 and HALT is absent.

## Structure
- Shared package fetch_pkg:
  - state encoding: localparams IDLE=0, REQ=1, WAIT=2, HOLD=3, HALT=4, width 3
  - PC increment constant 32'd4
  - alignment mask
- One sub-module: fetch_pc_next, combinational next-PC select among hold, pc+4, redirect target and alignment handling. Its select is driven by the FSM.

## Test plan
- Reset release with RESET_ADDR=32'h100, gnt=1 always, rvalid one cycle after grant, ready=1 -> addresses 0x100, 0x104, 0x108, with o_inst_valid every third cycle and o_inst_pc matching.
- gnt held low for 4 cycles in REQ -> o_imem_req and o_imem_addr stay stable, no state advance, then normal fetch.
- Redirect to 0x200 during WAIT, then rvalid with 0xDEADBEEF -> word dropped and o_inst_valid never asserts for it; next request address is 0x200.
- HOLD with ready=1 and redirect to 0x40 in the same cycle -> next request address is 0x40, not pc+4.
- pc=32'hFFFF_FFFC consumed -> next request address is 32'h0000_0000.
- Macro on, redirect to 0x202 -> o_trap=1 and o_trap_addr=0x202 next cycle, no further requests until reset. Macro off, same stimulus -> request address 0x200, o_trap=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// next-PC select, PC increment and word-alignment helpers.
package fetch_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] IDLE = 3'd0;
   localparam logic [STATE_W-1:0] REQ  = 3'd1;
   localparam logic [STATE_W-1:0] WAIT = 3'd2;
   localparam logic [STATE_W-1:0] HOLD = 3'd3;
   localparam logic [STATE_W-1:0] HALT = 3'd4;

   localparam logic [31:0] PC_INC     = 32'd4;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      PC_SEL_HOLD,
      PC_SEL_INC,
      PC_SEL_REDIRECT
   } pc_sel_e;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr & ~ALIGN_MASK) != 32'd0;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/grant/response,
// decode valid/ready, redirect input and trap report.
interface fetch_ctrl_if;

   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;

   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;

   logic        i_redirect;
   logic [31:0] i_redirect_target;

   logic        o_trap;
   logic [31:0] o_trap_addr;

   modport master (
      output o_imem_req, o_imem_addr,
      input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
      output o_inst_valid, o_inst, o_inst_pc,
      input  i_inst_ready,
      input  i_redirect, i_redirect_target,
      output o_trap, o_trap_addr
   );

   modport slave (
      input  o_imem_req, o_imem_addr,
      output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
      input  o_inst_valid, o_inst, o_inst_pc,
      output i_inst_ready,
      output i_redirect, i_redirect_target,
      input  o_trap, o_trap_addr
   );

endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: hold, sequential +4, or redirect target.
// Without FETCH_MISALIGN_TRAP_EN the target's low two bits are forced to zero.
module fetch_pc_next
   import fetch_pkg::*;
(
   input  logic [31:0] pc_i,
   input  pc_sel_e     sel_i,
   input  logic [31:0] target_i,
   output logic [31:0] pc_next_o
);

   logic [31:0] target_aligned;

`ifdef FETCH_MISALIGN_TRAP_EN
   // A misaligned target sends the FSM to HALT, so the raw value is harmless.
   assign target_aligned = target_i;
`else
   assign target_aligned = target_i & ALIGN_MASK;
`endif

   // NOTE: default assignment first so no path through the case leaves the output unassigned (no latch).
   always_comb begin
      pc_next_o = pc_i;
      case (sel_i)
         PC_SEL_INC:      pc_next_o = pc_i + PC_INC;
         PC_SEL_REDIRECT: pc_next_o = target_aligned;
         default:         pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read at a time and
// hands words to decode. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic         i_clk,
   input  logic         i_rst,
   fetch_ctrl_if.master bus
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic               kill_q, kill_d;
   logic [31:0]        inst_q, inst_d;
   logic [31:0]        inst_pc_q, inst_pc_d;
   logic               trap_q, trap_d;
   logic [31:0]        trap_addr_q, trap_addr_d;
   pc_sel_e            pc_sel;
   logic               redirect_ok;
   logic               trap_hit;

   assign redirect_ok = bus.i_redirect &&
                        (state_q == REQ || state_q == WAIT || state_q == HOLD);

`ifdef FETCH_MISALIGN_TRAP_EN
   assign trap_hit = redirect_ok && is_misaligned(bus.i_redirect_target);
`else
   assign trap_hit = 1'b0;
`endif

   fetch_pc_next u_pc_next (
      .pc_i      (pc_q),
      .sel_i     (pc_sel),
      .target_i  (bus.i_redirect_target),
      .pc_next_o (pc_d)
   );

   always_comb begin
      state_d     = state_q;
      kill_d      = kill_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;
      trap_d      = trap_q;
      trap_addr_d = trap_addr_q;
      pc_sel      = PC_SEL_HOLD;

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            // An accepted request that is already stale must still be drained.
            if (bus.i_imem_gnt) begin
               state_d = WAIT;
               kill_d  = redirect_ok;
            end
         end
         WAIT: begin
            if (bus.i_imem_rvalid) begin
               kill_d = 1'b0;
               if (kill_q || redirect_ok) begin
                  state_d = REQ;
               end else begin
                  inst_d    = bus.i_imem_rdata;
                  inst_pc_d = pc_q;
                  state_d   = HOLD;
               end
            end else if (redirect_ok) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_ok) begin
               state_d = REQ;
            end else if (bus.i_inst_ready) begin
               state_d = REQ;
               pc_sel  = PC_SEL_INC;
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase

      if (redirect_ok) pc_sel = PC_SEL_REDIRECT;

      if (trap_hit) begin
         state_d     = HALT;
         kill_d      = 1'b0;
         trap_d      = 1'b1;
         trap_addr_d = bus.i_redirect_target;
      end
   end

   // NOTE: every register here has a defined reset value; the async reset branch must cover all of them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_ADDR;
         kill_q      <= 1'b0;
         inst_q      <= 32'd0;
         inst_pc_q   <= 32'd0;
         trap_q      <= 1'b0;
         trap_addr_q <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so all state updates see pre-edge values.
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         inst_q      <= inst_d;
         inst_pc_q   <= inst_pc_d;
         trap_q      <= trap_d;
         trap_addr_q <= trap_addr_d;
      end
   end

   assign bus.o_imem_req   = (state_q == REQ);
   assign bus.o_imem_addr  = pc_q;
   assign bus.o_inst_valid = (state_q == HOLD);
   assign bus.o_inst       = inst_q;
   assign bus.o_inst_pc    = inst_pc_q;
   assign bus.o_trap       = trap_q;
   assign bus.o_trap_addr  = trap_addr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios then randomized traffic,
// checked against a program-order fetch model. Honours FETCH_MISALIGN_TRAP_EN.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic clk;
   logic rst;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.RESET_ADDR(RST_PC)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   // Reference model: architectural fetch PC, the one outstanding memory read,
   // and the queue of words decode is expected to see, in order.
   exp_t        exp_q[$];
   logic [31:0] m_pc;
   bit          m_out;
   bit          m_out_stale;
   logic [31:0] m_out_addr;
   logic [31:0] m_out_data;
   bit          m_halted;
   logic [31:0] m_trap_addr;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0110) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit model_req();
      return !m_out && exp_q.size() == 0 && !m_halted;
   endfunction

   // Monitor: compares every post-edge output against the model.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         check("req", {31'd0, bus.o_imem_req}, {31'd0, model_req()});
         if (model_req()) check("addr", bus.o_imem_addr, m_pc);
         check("valid", {31'd0, bus.o_inst_valid}, {31'd0, exp_q.size() > 0});
         if (exp_q.size() > 0) begin
            check("inst", bus.o_inst, exp_q[0].inst);
            check("inst_pc", bus.o_inst_pc, exp_q[0].pc);
         end
         check("trap", {31'd0, bus.o_trap}, {31'd0, m_halted});
         check("trap_addr", bus.o_trap_addr, m_trap_addr);
      end
   end

   task automatic drive_idle();
      bus.i_imem_gnt        = 1'b0;
      bus.i_imem_rvalid     = 1'b0;
      bus.i_imem_rdata      = 32'd0;
      bus.i_inst_ready      = 1'b0;
      bus.i_redirect        = 1'b0;
      bus.i_redirect_target = 32'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      #1;
      check("rst_req", {31'd0, bus.o_imem_req}, 32'd0);
      check("rst_addr", bus.o_imem_addr, RST_PC);
      check("rst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
      check("rst_inst", bus.o_inst, 32'd0);
      check("rst_inst_pc", bus.o_inst_pc, 32'd0);
      check("rst_trap", {31'd0, bus.o_trap}, 32'd0);
      check("rst_trap_addr", bus.o_trap_addr, 32'd0);
      m_pc        = RST_PC;
      m_out       = 1'b0;
      m_out_stale = 1'b0;
      m_halted    = 1'b0;
      m_trap_addr = 32'd0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_req", {31'd0, bus.o_imem_req}, 32'd0);
   endtask

   // One cycle of stimulus; the model is advanced for the coming rising edge.
   task automatic step(input bit gnt, input bit rv, input bit rdy, input bit rd,
                       input logic [31:0] tgt);
      bit pending;
      bit grant;
      bit resp;
      bit rd_eff;
      @(negedge clk);
      pending = exp_q.size() > 0;
      grant   = model_req() && gnt;
      resp    = m_out && rv;
      rd_eff  = rd && !m_halted;

      bus.i_imem_gnt        = gnt;
      bus.i_imem_rvalid     = resp;
      bus.i_imem_rdata      = resp ? m_out_data : $urandom;
      bus.i_inst_ready      = rdy;
      bus.i_redirect        = rd;
      bus.i_redirect_target = tgt;

      if (m_out && !resp && rd_eff) m_out_stale = 1'b1;
      if (resp) begin
         m_out = 1'b0;
         if (!m_out_stale && !rd_eff && !m_halted)
            exp_q.push_back('{inst: m_out_data, pc: m_out_addr});
      end
      if (grant) begin
         m_out       = 1'b1;
         m_out_stale = rd_eff;
         m_out_addr  = m_pc;
         m_out_data  = mem_word(m_pc);
      end
      if (pending) begin
         if (rd_eff) begin
            void'(exp_q.pop_front());
         end else if (rdy) begin
            void'(exp_q.pop_front());
            m_pc = m_pc + 32'd4;
         end
      end
      if (rd_eff) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         if (tgt[1:0] != 2'b00) begin
            m_halted    = 1'b1;
            m_trap_addr = tgt;
            exp_q.delete();
         end else begin
            m_pc = tgt;
         end
`else
         m_pc = {tgt[31:2], 2'b00};
`endif
      end
   endtask

   task automatic post_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive_idle();
      do_reset();

      // Back-to-back best-case fetches: 0x100, 0x104, 0x108.
      for (int i = 0; i < 9; i++) step(1, 1, 1, 0, 32'd0);
      post_edge();
      check("seq_addr", bus.o_imem_addr, 32'h0000_010C);

      // Grant withheld for four cycles.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'd0);
      post_edge();
      check("stall_req", {31'd0, bus.o_imem_req}, 32'd1);
      check("stall_addr", bus.o_imem_addr, 32'h0000_010C);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'd0);

      // Redirect while waiting; the 0xDEADBEEF response must be dropped.
      step(1, 0, 0, 0, 32'd0);
      step(0, 0, 0, 1, 32'h0000_0200);
      step(0, 1, 0, 0, 32'd0);
      post_edge();
      check("kill_valid", {31'd0, bus.o_inst_valid}, 32'd0);
      check("kill_addr", bus.o_imem_addr, 32'h0000_0200);

      // Ready and redirect together in HOLD: redirect wins.
      step(1, 0, 0, 0, 32'd0);
      step(0, 1, 0, 0, 32'd0);
      step(0, 0, 1, 1, 32'h0000_0040);
      post_edge();
      check("hold_redir_addr", bus.o_imem_addr, 32'h0000_0040);

      // PC wrap-around.
      step(0, 0, 0, 1, 32'hFFFF_FFFC);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'd0);
      post_edge();
      check("wrap_addr", bus.o_imem_addr, 32'h0000_0000);

      // Misaligned redirect.
      step(0, 0, 0, 1, 32'h0000_0202);
      post_edge();
`ifdef FETCH_MISALIGN_TRAP_EN
      check("mis_trap", {31'd0, bus.o_trap}, 32'd1);
      check("mis_trap_addr", bus.o_trap_addr, 32'h0000_0202);
      check("mis_req", {31'd0, bus.o_imem_req}, 32'd0);
`else
      check("mis_trap", {31'd0, bus.o_trap}, 32'd0);
      check("mis_addr", bus.o_imem_addr, 32'h0000_0200);
`endif
      for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 32'd0);

      // Randomized traffic, with a mid-operation reset starting each block.
      for (int blk = 0; blk < 6; blk++) begin
         do_reset();
         for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 8, tgt);
         end
      end

      post_edge();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
